// File: rtl/servant_gpio_bank_if.sv
// Wishbone slave bus for servant_gpio_bank: word-addressed, single-cycle ack.
interface servant_gpio_bank_if;
    logic [2:0]  i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [3:0]  i_wb_sel;
    logic        i_wb_we;
    logic        i_wb_cyc;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;

    modport master (
        output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc,
        input  o_wb_rdt, o_wb_ack
    );

    modport slave (
        input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc,
        output o_wb_rdt, o_wb_ack
    );
endinterface

// File: rtl/servant_gpio_bank.sv
// Parametrised Wishbone GPIO bank: OUT/DIR/IN registers plus optional edge interrupts.
// Define SERVANT_GPIO_BANK_IRQ_EN to build the MASK/PEND rising-edge interrupt logic.
module servant_gpio_bank #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    servant_gpio_bank_if.slave   wb,
    input  logic [WIDTH-1:0]     i_gpio,
    output logic [WIDTH-1:0]     o_gpio,
    output logic [WIDTH-1:0]     o_gpio_oe,
    output logic                 o_irq
);

    localparam logic [2:0] ADR_OUT  = 3'd0;
    localparam logic [2:0] ADR_DIR  = 3'd1;
    localparam logic [2:0] ADR_IN   = 3'd2;
    localparam logic [2:0] ADR_MASK = 3'd3;
    localparam logic [2:0] ADR_PEND = 3'd4;

    logic                r_ack;
    logic [31:0]         r_rdt;
    logic [WIDTH-1:0]    r_out;
    logic [WIDTH-1:0]    r_dir;
    logic [WIDTH-1:0]    r_sync [SYNC_STAGES];

    logic                w_req;
    logic                w_wr;
    logic [31:0]         w_lane;
    logic [31:0]         w_rd;
    logic [WIDTH-1:0]    w_in;
    logic [WIDTH-1:0]    w_mask;
    logic [WIDTH-1:0]    w_pend;

    // Byte-lane merge done at 32 bits so any WIDTH (including 32) slices cleanly.
    function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old,
                                               input logic [31:0]      dat,
                                               input logic [31:0]      lane);
        logic [31:0] v;
        v = '0;
        v[WIDTH-1:0] = old;
        v = (v & ~lane) | (dat & lane);
        return v[WIDTH-1:0];
    endfunction

    assign w_req = wb.i_wb_cyc & ~r_ack;
    assign w_wr  = w_req & wb.i_wb_we;
    assign w_in  = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_lane = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            w_lane[8*k +: 8] = {8{wb.i_wb_sel[k]}};
        end
    end

    always_comb begin
        w_rd = '0;
        case (wb.i_wb_adr)
            ADR_OUT:  w_rd[WIDTH-1:0] = r_out;
            ADR_DIR:  w_rd[WIDTH-1:0] = r_dir;
            ADR_IN:   w_rd[WIDTH-1:0] = w_in;
            ADR_MASK: w_rd[WIDTH-1:0] = w_mask;
            ADR_PEND: w_rd[WIDTH-1:0] = w_pend;
            default:  w_rd = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack <= 1'b0;
            r_rdt <= '0;
            r_out <= RESET_OUT;
            r_dir <= RESET_DIR;
        end else begin
            r_ack <= w_req;
            r_rdt <= w_req ? w_rd : '0;
            if (w_wr) begin
                case (wb.i_wb_adr)
                    ADR_OUT: r_out <= merge(r_out, wb.i_wb_dat, w_lane);
                    ADR_DIR: r_dir <= merge(r_dir, wb.i_wb_dat, w_lane);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= i_gpio;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

`ifdef SERVANT_GPIO_BANK_IRQ_EN
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_pend;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_clr;

    assign w_rise = w_in & ~r_prev;
    assign w_clr  = (w_wr && wb.i_wb_adr == ADR_PEND)
                  ? merge('0, wb.i_wb_dat, w_lane) : '0;

    // A new edge in the same cycle as its W1C keeps the bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= '0;
            r_pend <= '0;
            r_prev <= '0;
        end else begin
            r_prev <= w_in;
            r_pend <= (r_pend & ~w_clr) | w_rise;
            if (w_wr && wb.i_wb_adr == ADR_MASK) begin
                r_mask <= merge(r_mask, wb.i_wb_dat, w_lane);
            end
        end
    end

    assign w_mask = r_mask;
    assign w_pend = r_pend;
    assign o_irq  = |(r_pend & r_mask);
`else
    assign w_mask = '0;
    assign w_pend = '0;
    assign o_irq  = 1'b0;
`endif

    assign wb.o_wb_ack = r_ack;
    assign wb.o_wb_rdt = r_rdt;
    assign o_gpio      = r_out;
    assign o_gpio_oe   = r_dir;

endmodule
